sync_fifo_buf: RTL and testbench
================================

// Module: sync_fifo_buf
// PURPOSE
//  Single-clock, parametrised data FIFO: write port, read port, status flags and word count.
//  Storage is a register file, written on a clock edge and read asynchronously (no fixed 8x36 array).
//  Buffers hit/trailer words between the readout stages of the emulator.
//  Adds flush, almost-full, sticky over/underflow error flags and a selectable read mode.
// PARAMETERS
//  DATA_WIDTH   36  width of one FIFO word
//  ADDR_WIDTH   3   log2(depth); DEPTH = 2**ADDR_WIDTH (default 8)
//  AFULL_THRESH 6   almost_full asserts when word_cnt >= AFULL_THRESH (1..DEPTH)
// PORTS
//  wclk        in   1             clock; all logic on its rising edge
//  wrst_n      in   1             asynchronous active-low reset
//  flush       in   1             synchronous clear of pointers and count
//  winc        in   1             write request
//  wdata       in   DATA_WIDTH    write data
//  rinc        in   1             read request
//  rdata       out  DATA_WIDTH    read data (timing depends on SYNC_FIFO_FWFT_EN)
//  rvalid      out  1             rdata qualifier
//  wfull       out  1             word_cnt == DEPTH
//  rempty      out  1             word_cnt == 0
//  almost_full out  1             word_cnt >= AFULL_THRESH
//  word_cnt    out  ADDR_WIDTH+1  number of stored words, 0..DEPTH
//  overflow    out  1             sticky: set by winc while wfull
//  underflow   out  1             sticky: set by rinc while rempty
//  clr_err     in   1             clears overflow/underflow
// BEHAVIOUR
//  - Reset values: wptr = rptr = 0; word_cnt = 0; rempty = 1; wfull = 0; almost_full = 0;
//    overflow = 0; underflow = 0; rvalid = 0; registered rdata = 0. Memory is not reset.
//  - Pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2*DEPTH.
//    Empty: wptr == rptr. Full: the MSBs differ and the lower bits are equal.
//  - word_cnt is the registered value of wptr - rptr; it is never computed by a sum.
//  - Write accepted = winc & !wfull. Read accepted = rinc & !rempty.
//    Both depend only on the flags at the start of the cycle.
//  - When full, a write is rejected even if a read is accepted in the same cycle.
//  - When empty, a read is rejected even if a write is accepted in the same cycle.
//  - Both accepted in one cycle: count unchanged, both pointers advance.
//  - Flags and word_cnt update on the same edge as the pointers; latency is 1 cycle.
//  - overflow sets on (winc & wfull); underflow sets on (rinc & rempty).
//    Each holds until clr_err. Set takes priority over clr_err in the same cycle.
//  - flush: on the next edge, pointers = 0, count = 0, rempty = 1, rvalid = 0.
//    Flush overrides any write or read in the same cycle (both are dropped and flag no error).
//    Error flags and memory contents are kept.
//  - Reset mid-operation clears all state at once; no write completes during reset.
// CONFIGURATION
//  - SYNC_FIFO_FWFT_EN defined (first-word fall-through):
//    rdata = mem[rptr] combinationally; rvalid = !rempty.
//    A read accepted at edge N shows the next word after edge N.
//  - SYNC_FIFO_FWFT_EN undefined (standard mode):
//    rdata is a register loaded with mem[rptr] on an accepted read.
//    rvalid pulses high for the 1 cycle after each accepted read; rdata holds between reads.
// STRUCTURE
//  - Globals.v: default width/depth `defines and an overflow-error code constant.
//  - One sub-module, sync_fifo_mem: DEPTH x DATA_WIDTH array.
//    Interface: wclk, wen, waddr, wdata, raddr, rdata.
//    Write is synchronous; read is asynchronous.
//  - The top level holds the pointers, flags, counters and the read-mode logic.
// TESTING
//  1. Write 8 words 0x0_0000_0001..0x0_0000_0008, no reads:
//     wfull = 1 after the 8th edge, almost_full after the 6th, word_cnt = 8, overflow = 0.
//  2. Full FIFO, winc once more with 0xF_FFFF_FFFF: word not stored, overflow = 1.
//     Read back 8 words: original order, rempty = 1 at the end.
//  3. Empty FIFO, rinc = 1 for 1 cycle: underflow = 1, rvalid stays 0, pointers unchanged.
//     clr_err for 1 cycle: both error flags return to 0.
//  4. 4 words stored, winc & rinc together for 20 cycles with an incrementing pattern:
//     word_cnt stays 4, data comes out in order, pointers wrap past 15 to 0.
//  5. 5 words stored, flush together with winc & rinc: next cycle word_cnt = 0, rempty = 1, no error set.
//     Then deassert wrst_n during a write burst: all outputs reach reset values.
//  6. Run with SYNC_FIFO_FWFT_EN both defined and undefined, write 0xA, 0xB:
//     FWFT shows 0xA on rdata with no rinc.
//     Standard mode shows 0xA with rvalid = 1 in the cycle after the first accepted rinc.

Source files
------------

// File: rtl/sync_fifo_buf_pkg.sv
// Shared constants and types for the readout-stage word FIFO (sync_fifo_buf).
// Holds the default geometry and the error codes reported by the FIFO.
package sync_fifo_buf_pkg;

  localparam int DEF_DATA_WIDTH   = 36;
  localparam int DEF_ADDR_WIDTH   = 3;
  localparam int DEF_AFULL_THRESH = 6;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2
  } fifo_err_e;

  // Code reported upstream when a write hits a full buffer.
  localparam fifo_err_e OVERFLOW_ERR_CODE = ERR_OVERFLOW;

  typedef struct packed {
    logic wfull;
    logic rempty;
    logic almost_full;
  } fifo_flags_t;

endpackage : sync_fifo_buf_pkg

// File: rtl/sync_fifo_mem.sv
// Register-file storage for sync_fifo_buf: synchronous write, asynchronous read.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  wclk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; stale words are never visible because the
  // pointers/flags gate every read, and a resettable array costs a mux per bit.
  always_ff @(posedge wclk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_buf.sv
// Single-clock hit/trailer word FIFO with flush, almost-full and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through; default is registered-read mode.
import sync_fifo_buf_pkg::*;

module sync_fifo_buf #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  flush,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic [ADDR_WIDTH:0]   wptr_nxt, rptr_nxt, cnt_nxt;
  fifo_flags_t           flags_nxt;
  logic                  wr_acc, rd_acc;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Acceptance looks only at the registered flags, so a simultaneous read
  // never frees room for a write on a full FIFO (and vice versa when empty).
  assign wr_acc  = winc & ~wfull  & ~flush;
  assign rd_acc  = rinc & ~rempty & ~flush;
  assign mem_wen = wr_acc & wrst_n;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .wclk  (wclk),
    .wen   (mem_wen),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned and a latch is inferred.
  always_comb begin
    wptr_nxt = wptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rptr_nxt = rptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
    if (flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end
    cnt_nxt               = wptr_nxt - rptr_nxt;
    flags_nxt.rempty      = (wptr_nxt == rptr_nxt);
    flags_nxt.wfull       = (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                            (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
    flags_nxt.almost_full = (cnt_nxt >= AFULL_CNT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      word_cnt    <= '0;
      wfull       <= 1'b0;
      rempty      <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      word_cnt    <= cnt_nxt;
      wfull       <= flags_nxt.wfull;
      rempty      <= flags_nxt.rempty;
      almost_full <= flags_nxt.almost_full;
    end
  end

  // Sticky errors: a new error wins over clr_err; flush drops the request silently.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull && !flush) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rinc && rempty && !flush) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = mem_rdata;
  assign rvalid = ~rempty;
`else
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule : sync_fifo_buf

// File: tb/tb_sync_fifo_buf.sv
// Directed self-checking bench for sync_fifo_buf; follows SYNC_FIFO_FWFT_EN like the RTL.
module tb_sync_fifo_buf;

  localparam int DW = 36;
  localparam int AW = 3;

  logic          wclk;
  logic          wrst_n;
  logic          flush;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          rinc;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          wfull;
  logic          rempty;
  logic          almost_full;
  logic [AW:0]   word_cnt;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  int checks;
  int errors;

  sync_fifo_buf #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (6)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .flush       (flush),
    .winc        (winc),
    .wdata       (wdata),
    .rinc        (rinc),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .wfull       (wfull),
    .rempty      (rempty),
    .almost_full (almost_full),
    .word_cnt    (word_cnt),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // One clock cycle with the given requests; returns the word presented for
  // this read (before the edge in FWFT mode, after it in registered mode).
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                       output logic [DW-1:0] word, output logic vld);
    winc  = w;
    wdata = d;
    rinc  = r;
`ifdef SYNC_FIFO_FWFT_EN
    #1;
    word = rdata;
    vld  = rvalid;
    tick();
`else
    tick();
    word = rdata;
    vld  = rvalid;
`endif
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; flush = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
    tick(); tick();
    checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", word_cnt); end
    checks++; if ({wfull, rempty, almost_full} !== 3'b010) begin errors++; $display("FAIL reset_flags got %b exp 010", {wfull, rempty, almost_full}); end
    checks++; if ({overflow, underflow, rvalid} !== 3'b000) begin errors++; $display("FAIL reset_err_vld got %b exp 000", {overflow, underflow, rvalid}); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
`endif
    wrst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    logic [DW-1:0] word;
    logic          vld;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), 1'b0, word, vld);
      checks++; if (word_cnt !== 4'(i)) begin errors++; $display("FAIL fill_cnt[%0d] got %0d exp %0d", i, word_cnt, i); end
      checks++; if (almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, (i >= 6)); end
      checks++; if (wfull !== (i == 8)) begin errors++; $display("FAIL fill_wfull[%0d] got %b exp %b", i, wfull, (i == 8)); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_overflow_readback();
    logic [DW-1:0] word;
    logic          vld;
    cycle(1'b1, 36'hF_FFFF_FFFF, 1'b0, word, vld);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (word_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt got %0d exp 8", word_cnt); end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, '0, 1'b1, word, vld);
      checks++; if (word !== DW'(i) || vld !== 1'b1) begin errors++; $display("FAIL readback[%0d] got %h/%b exp %h/1", i, word, vld, DW'(i)); end
    end
    checks++; if (rempty !== 1'b1 || word_cnt !== 4'd0) begin errors++; $display("FAIL readback_empty got %b/%0d exp 1/0", rempty, word_cnt); end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] word;
    logic          vld;
    cycle(1'b0, '0, 1'b1, word, vld);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set got %b exp 1", underflow); end
    checks++; if (vld !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL udf_rvalid got %b/%b exp 0/0", vld, rvalid); end
    checks++; if (dut.wptr !== 4'd8 || dut.rptr !== 4'd8) begin errors++; $display("FAIL udf_ptrs got %0d/%0d exp 8/8", dut.wptr, dut.rptr); end
    rinc = 1'b1; clr_err = 1'b1;
    tick();
    rinc = 1'b0;
    checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL set_beats_clr got %b/%b exp udf 1 ovf 0", underflow, overflow); end
    tick();
    clr_err = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_err got %b exp 00", {overflow, underflow}); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] word;
    logic          vld;
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(100 + i), 1'b0, word, vld);
    checks++; if (word_cnt !== 4'd4) begin errors++; $display("FAIL b2b_prefill got %0d exp 4", word_cnt); end
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, DW'(104 + k), 1'b1, word, vld);
      checks++; if (word !== DW'(100 + k) || vld !== 1'b1 || word_cnt !== 4'd4) begin
        errors++; $display("FAIL b2b[%0d] got %h/%b/%0d exp %h/1/4", k, word, vld, word_cnt, DW'(100 + k));
      end
    end
    checks++; if (dut.wptr !== 4'd0 || dut.rptr !== 4'd12) begin errors++; $display("FAIL b2b_wrap got %0d/%0d exp 0/12", dut.wptr, dut.rptr); end
  endtask

  task automatic test_flush_reset();
    logic [DW-1:0] word;
    logic          vld;
    cycle(1'b1, DW'(124), 1'b0, word, vld);
    checks++; if (word_cnt !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d exp 5", word_cnt); end
    flush = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = DW'(999);
    tick();
    flush = 1'b0; winc = 1'b0; rinc = 1'b0;
    checks++; if (word_cnt !== 4'd0 || rempty !== 1'b1 || wfull !== 1'b0) begin errors++; $display("FAIL flush_state got %0d/%b/%b exp 0/1/0", word_cnt, rempty, wfull); end
    checks++; if ({overflow, underflow, rvalid} !== 3'b000) begin errors++; $display("FAIL flush_err got %b exp 000", {overflow, underflow, rvalid}); end
    checks++; if (dut.wptr !== 4'd0 || dut.rptr !== 4'd0) begin errors++; $display("FAIL flush_ptrs got %0d/%0d exp 0/0", dut.wptr, dut.rptr); end
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(200 + i), 1'b0, word, vld);
    winc = 1'b1; wdata = DW'(203);
    #2 wrst_n = 1'b0;
    #1;
    checks++; if (word_cnt !== 4'd0 || {wfull, rempty, almost_full} !== 3'b010) begin errors++; $display("FAIL rst_async got %0d/%b exp 0/010", word_cnt, {wfull, rempty, almost_full}); end
    tick();
    checks++; if (word_cnt !== 4'd0 || dut.wptr !== 4'd0 || {overflow, underflow, rvalid} !== 3'b000) begin errors++; $display("FAIL rst_hold got %0d/%0d/%b exp 0/0/000", word_cnt, dut.wptr, {overflow, underflow, rvalid}); end
    winc = 1'b0;
    wrst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_mode();
    logic [DW-1:0] word;
    logic          vld;
    cycle(1'b1, 36'hA, 1'b0, word, vld);
    cycle(1'b1, 36'hB, 1'b0, word, vld);
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (rdata !== 36'hA || rvalid !== 1'b1) begin errors++; $display("FAIL fwft_head got %h/%b exp a/1", rdata, rvalid); end
    cycle(1'b0, '0, 1'b1, word, vld);
    checks++; if (rdata !== 36'hB || rvalid !== 1'b1) begin errors++; $display("FAIL fwft_next got %h/%b exp b/1", rdata, rvalid); end
    cycle(1'b0, '0, 1'b1, word, vld);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL fwft_drain got %b exp 0", rvalid); end
`else
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL std_idle got %b exp 0", rvalid); end
    cycle(1'b0, '0, 1'b1, word, vld);
    checks++; if (word !== 36'hA || vld !== 1'b1) begin errors++; $display("FAIL std_first got %h/%b exp a/1", word, vld); end
    tick();
    checks++; if (rdata !== 36'hA || rvalid !== 1'b0) begin errors++; $display("FAIL std_hold got %h/%b exp a/0", rdata, rvalid); end
    cycle(1'b0, '0, 1'b1, word, vld);
    checks++; if (word !== 36'hB || vld !== 1'b1) begin errors++; $display("FAIL std_second got %h/%b exp b/1", word, vld); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_overflow_readback();
    test_underflow();
    test_back_to_back();
    test_flush_reset();
    test_read_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo_buf
